// File: rtl/frag_ifetch_if.sv
// frag_ifetch_if: instruction-memory request/response channel between fetch and imem.
interface frag_ifetch_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data
  );
  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data
  );
endinterface

// File: rtl/frag_ifetch.sv
// frag_ifetch: RV32I fetch stage and IF/ID register, one outstanding imem request,
// one-entry skid buffer absorbing the in-flight word while decode stalls.
module frag_ifetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_stall,
  input  logic                i_redirect,
  input  logic [31:0]         i_redirect_pc,
  frag_ifetch_if.master       imem,
  output logic                o_inst_valid,
  output logic [31:0]         o_inst_data,
  output logic [31:0]         o_inst_pc
);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, FULL, DROP} state_t;
  localparam logic [31:0] PC0 = RESET_PC & ~32'h3;
  localparam logic [31:0] NOP = 32'h0000_0013;
  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, r_req_pc, r_skid_data, r_skid_pc;
  logic [31:0] w_pc_nxt, w_req_pc_nxt;
  logic        w_accept, w_rsp, w_free, w_load_rsp, w_load_skid, w_from_skid;

  assign imem.imem_req_valid = r_state == REQ;
  assign imem.imem_req_addr  = r_pc;
  assign w_accept = r_state == REQ && imem.imem_req_ready;
  assign w_rsp    = imem.imem_rsp_valid;
  assign w_free   = !o_inst_valid || !i_stall;

  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_req_pc_nxt = r_req_pc;
    w_load_rsp   = 1'b0;
    w_load_skid  = 1'b0;
    w_from_skid  = 1'b0;
    case (r_state)
      IDLE: w_state_nxt = REQ;
      REQ: begin
        w_req_pc_nxt = w_accept ? r_pc : r_req_pc;
        w_state_nxt  = w_accept ? WAIT : REQ;
      end
      WAIT: if (w_rsp) begin
        w_pc_nxt    = r_req_pc + 32'd4;
        w_load_rsp  = w_free;
        w_load_skid = !w_free;
        w_state_nxt = w_free ? REQ : FULL;
      end
      FULL: begin
        w_from_skid = !i_stall;
        w_state_nxt = i_stall ? FULL : REQ;
      end
      DROP: w_state_nxt = w_rsp ? REQ : DROP;
      default: w_state_nxt = IDLE;
    endcase
    // redirect overrides everything; stay in DROP only while a response is still owed
    if (i_redirect) begin
      w_pc_nxt    = i_redirect_pc & ~32'h3;
      w_load_rsp  = 1'b0;
      w_load_skid = 1'b0;
      w_from_skid = 1'b0;
      w_state_nxt = (((r_state == WAIT || r_state == DROP) && !w_rsp) || w_accept) ? DROP : REQ;
    end
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state      <= IDLE;
      r_pc         <= PC0;
      r_req_pc     <= PC0;
      r_skid_data  <= NOP;
      r_skid_pc    <= PC0;
      o_inst_valid <= 1'b0;
      o_inst_data  <= NOP;
      o_inst_pc    <= PC0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_req_pc     <= w_req_pc_nxt;
      o_inst_valid <= w_load_rsp || w_from_skid || (o_inst_valid && i_stall && !i_redirect);
      if (w_load_skid) begin
        r_skid_data <= imem.imem_rsp_data;
        r_skid_pc   <= r_req_pc;
      end
      if (w_load_rsp) begin
        o_inst_data <= imem.imem_rsp_data;
        o_inst_pc   <= r_req_pc;
      end else if (w_from_skid) begin
        o_inst_data <= r_skid_data;
        o_inst_pc   <= r_skid_pc;
      end
    end
endmodule

// File: tb/tb_frag_ifetch.sv
// tb_frag_ifetch: directed checks of frag_ifetch fetch, stall/skid, redirect, back-pressure,
// PC wrap-around and asynchronous reset.
module tb_frag_ifetch;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        ready_a = 1'b1;
  int          lat_a = 1;
  int          cnt_a;
  int          checks = 0;
  int          errors = 0;
  logic        va, vb;
  logic [31:0] da, pa, db, pb;

  frag_ifetch_if ia ();
  frag_ifetch_if ib ();

  frag_ifetch #(.RESET_PC(32'h0000_0000)) dut_a (
    .clk(clk), .rst(rst), .i_stall(stall), .i_redirect(redirect), .i_redirect_pc(redirect_pc),
    .imem(ia.master), .o_inst_valid(va), .o_inst_data(da), .o_inst_pc(pa)
  );

  frag_ifetch #(.RESET_PC(32'hFFFF_FFFC)) dut_b (
    .clk(clk), .rst(rst), .i_stall(1'b0), .i_redirect(1'b0), .i_redirect_pc(32'h0),
    .imem(ib.master), .o_inst_valid(vb), .o_inst_data(db), .o_inst_pc(pb)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'h0050_0013;
  endfunction

  assign ia.imem_req_ready = ready_a;
  assign ib.imem_req_ready = 1'b1;

  always @(posedge clk or posedge rst)
    if (rst) begin
      cnt_a <= 0;
      ia.imem_rsp_valid <= 1'b0;
      ia.imem_rsp_data <= 32'h0;
    end else if (ia.imem_req_valid && ia.imem_req_ready) begin
      cnt_a <= lat_a - 1;
      ia.imem_rsp_valid <= lat_a == 1;
      ia.imem_rsp_data <= mem(ia.imem_req_addr);
    end else begin
      cnt_a <= cnt_a == 0 ? 0 : cnt_a - 1;
      ia.imem_rsp_valid <= cnt_a == 1;
    end

  always @(posedge clk or posedge rst)
    if (rst) begin
      ib.imem_rsp_valid <= 1'b0;
      ib.imem_rsp_data <= 32'h0;
    end else begin
      ib.imem_rsp_valid <= ib.imem_req_valid && ib.imem_req_ready;
      ib.imem_rsp_data <= mem(ib.imem_req_addr);
    end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tick();
    tick();
    chk("rst_req_valid", {31'h0, ia.imem_req_valid}, 32'h0);
    chk("rst_req_addr", ia.imem_req_addr, 32'h0);
    chk("rst_inst_valid", {31'h0, va}, 32'h0);
    chk("rst_inst_data", da, 32'h0000_0013);
    chk("rst_inst_pc", pa, 32'h0);
    chk("rst_b_addr", ib.imem_req_addr, 32'hFFFF_FFFC);
    chk("rst_b_inst_pc", pb, 32'hFFFF_FFFC);
    rst = 1'b0;
    tick();
    chk("e1_req_valid", {31'h0, ia.imem_req_valid}, 32'h1);
    chk("e1_req_addr", ia.imem_req_addr, 32'h0);
    chk("e1_b_req_valid", {31'h0, ib.imem_req_valid}, 32'h1);
    chk("e1_b_addr", ib.imem_req_addr, 32'hFFFF_FFFC);
    tick();
    chk("e2_inst_valid", {31'h0, va}, 32'h0);
    chk("e2_req_valid", {31'h0, ia.imem_req_valid}, 32'h0);
    tick();
    chk("e3_inst_valid", {31'h0, va}, 32'h1);
    chk("e3_inst_pc", pa, 32'h0);
    chk("e3_inst_data", da, mem(32'h0));
    chk("e3_b_inst_valid", {31'h0, vb}, 32'h1);
    chk("e3_b_inst_pc", pb, 32'hFFFF_FFFC);
    chk("e3_b_wrap_addr", ib.imem_req_addr, 32'h0);
    tick();
    chk("e4_inst_valid", {31'h0, va}, 32'h0);
    tick();
    chk("e5_inst_valid", {31'h0, va}, 32'h1);
    chk("e5_inst_pc", pa, 32'h4);
    chk("e5_inst_data", da, mem(32'h4));
    chk("e5_b_inst_pc", pb, 32'h0);
    chk("e5_b_inst_data", db, mem(32'h0));
    stall = 1'b1;
    tick();
    chk("stall1_valid", {31'h0, va}, 32'h1);
    chk("stall1_pc", pa, 32'h4);
    tick();
    chk("stall2_pc", pa, 32'h4);
    chk("stall2_req_valid", {31'h0, ia.imem_req_valid}, 32'h0);
    chk("stall2_addr", ia.imem_req_addr, 32'hC);
    tick();
    chk("stall3_pc", pa, 32'h4);
    chk("stall3_data", da, mem(32'h4));
    chk("stall3_req_valid", {31'h0, ia.imem_req_valid}, 32'h0);
    stall = 1'b0;
    tick();
    chk("skid_valid", {31'h0, va}, 32'h1);
    chk("skid_pc", pa, 32'h8);
    chk("skid_data", da, mem(32'h8));
    chk("skid_req_valid", {31'h0, ia.imem_req_valid}, 32'h1);
    chk("skid_req_addr", ia.imem_req_addr, 32'hC);
    tick();
    chk("e10_inst_valid", {31'h0, va}, 32'h0);
    tick();
    chk("e11_inst_pc", pa, 32'hC);
    chk("e11_inst_valid", {31'h0, va}, 32'h1);
    lat_a = 2;
    tick();
    chk("e12_inst_valid", {31'h0, va}, 32'h0);
    chk("e12_req_valid", {31'h0, ia.imem_req_valid}, 32'h0);
    redirect = 1'b1;
    redirect_pc = 32'h0000_0103;
    tick();
    redirect = 1'b0;
    chk("rdw_req_valid", {31'h0, ia.imem_req_valid}, 32'h0);
    chk("rdw_addr", ia.imem_req_addr, 32'h100);
    chk("rdw_inst_valid", {31'h0, va}, 32'h0);
    tick();
    chk("rdw_drop_valid", {31'h0, va}, 32'h0);
    chk("rdw_req_valid2", {31'h0, ia.imem_req_valid}, 32'h1);
    chk("rdw_addr2", ia.imem_req_addr, 32'h100);
    lat_a = 1;
    tick();
    tick();
    chk("rdw_tgt_valid", {31'h0, va}, 32'h1);
    chk("rdw_tgt_pc", pa, 32'h100);
    chk("rdw_tgt_data", da, mem(32'h100));
    redirect = 1'b1;
    redirect_pc = 32'h0000_0200;
    tick();
    redirect = 1'b0;
    chk("rda_req_valid", {31'h0, ia.imem_req_valid}, 32'h0);
    chk("rda_addr", ia.imem_req_addr, 32'h200);
    chk("rda_inst_valid", {31'h0, va}, 32'h0);
    tick();
    chk("rda_drop_valid", {31'h0, va}, 32'h0);
    chk("rda_req_valid2", {31'h0, ia.imem_req_valid}, 32'h1);
    chk("rda_addr2", ia.imem_req_addr, 32'h200);
    ready_a = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_req_valid", {31'h0, ia.imem_req_valid}, 32'h1);
      chk("bp_addr", ia.imem_req_addr, 32'h200);
      chk("bp_inst_valid", {31'h0, va}, 32'h0);
    end
    ready_a = 1'b1;
    tick();
    tick();
    chk("bp_done_valid", {31'h0, va}, 32'h1);
    chk("bp_done_pc", pa, 32'h200);
    chk("bp_done_data", da, mem(32'h200));
    stall = 1'b1;
    tick();
    chk("mid_pre_valid", {31'h0, va}, 32'h1);
    chk("mid_pre_pc", pa, 32'h200);
    #2;
    rst = 1'b1;
    #1;
    chk("async_inst_valid", {31'h0, va}, 32'h0);
    chk("async_req_valid", {31'h0, ia.imem_req_valid}, 32'h0);
    chk("async_addr", ia.imem_req_addr, 32'h0);
    chk("async_inst_pc", pa, 32'h0);
    chk("async_inst_data", da, 32'h0000_0013);
    stall = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk("rs1_req_valid", {31'h0, ia.imem_req_valid}, 32'h1);
    chk("rs1_addr", ia.imem_req_addr, 32'h0);
    tick();
    tick();
    chk("rs3_valid", {31'h0, va}, 32'h1);
    chk("rs3_pc", pa, 32'h0);
    chk("rs3_data", da, mem(32'h0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
